// File: rtl/spi_master_cfg_if.sv
// Host handshake plus SPI pin bundle for spi_master_cfg.
// The master modport is the SPI master's view; slave is the host/link side.
interface spi_master_cfg_if #(
  parameter int DATASIZE = 128
);
  logic                start;
  logic [1:0]          mode;
  logic [DATASIZE-1:0] tx_data;
  logic [DATASIZE-1:0] rx_data;
  logic                busy;
  logic                done;
  logic                sclk;
  logic                scs;
  logic                mosi;
  logic                miso;

  modport master (
    input  start, mode, tx_data, miso,
    output rx_data, busy, done, sclk, scs, mosi
  );

  modport slave (
    output start, mode, tx_data, miso,
    input  rx_data, busy, done, sclk, scs, mosi
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master: MSB-first DATASIZE-bit frames, programmable sclk divider,
// CS setup/hold gap and all four CPOL/CPHA modes, with start/busy/done handshake.
module spi_master_cfg #(
  parameter int DATASIZE = 128,
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  spi_master_cfg_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  localparam int GAP_CYC = (CS_GAP * CLK_DIV > 0) ? CS_GAP * CLK_DIV : 1;
  localparam int CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATASIZE + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATASIZE - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic [DATASIZE-1:0] tx_sh_q, tx_sh_d;
  logic [DATASIZE-1:0] rx_sh_q, rx_sh_d;
  logic [DATASIZE-1:0] rx_data_q, rx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                scs_q, scs_d;
  logic                mosi_q, mosi_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    scs_d     = scs_q;
    mosi_d    = mosi_q;

    case (state_q)
      IDLE: begin
        // busy is still high in the done cycle, which blocks a same-cycle restart
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (bus.start) begin
          cpol_d  = bus.mode[1];
          cpha_d  = bus.mode[0];
          sclk_d  = bus.mode[1];
          scs_d   = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          rx_sh_d = '0;
          state_d = SETUP;
          if (!bus.mode[0]) begin
            mosi_d  = bus.tx_data[DATASIZE-1];
            tx_sh_d = {bus.tx_data[DATASIZE-2:0], 1'b0};
          end else begin
            tx_sh_d = bus.tx_data;
          end
        end
      end

      SETUP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      XFER: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q == cpol_q) begin
            // leading edge of the bit
            if (cpha_q) begin
              mosi_d  = tx_sh_q[DATASIZE-1];
              tx_sh_d = {tx_sh_q[DATASIZE-2:0], 1'b0};
            end else begin
              rx_sh_d = {rx_sh_q[DATASIZE-2:0], bus.miso};
            end
          end else begin
            if (cpha_q) begin
              rx_sh_d = {rx_sh_q[DATASIZE-2:0], bus.miso};
            end else if (bit_q != BIT_LAST) begin
              mosi_d  = tx_sh_q[DATASIZE-1];
              tx_sh_d = {tx_sh_q[DATASIZE-2:0], 1'b0};
            end
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = HOLD;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d     = '0;
          scs_d     = 1'b1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      scs_q     <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      scs_q     <= scs_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_q;
  assign bus.scs     = scs_q;
  assign bus.mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: an 8-bit instance against a behavioural SPI slave and a
// 128-bit instance in mosi->miso loopback, with latency/handshake expectations from the frame rules.
module tb_spi_master_cfg;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  spi_master_cfg_if #(.DATASIZE(8))   if8 ();
  spi_master_cfg_if #(.DATASIZE(128)) if128 ();

  spi_master_cfg #(.DATASIZE(8), .CLK_DIV(2), .CS_GAP(2)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.master)
  );

  spi_master_cfg #(.DATASIZE(128), .CLK_DIV(1), .CS_GAP(1)) u_dut128 (
    .clk (clk),
    .rst (rst),
    .bus (if128.master)
  );

  assign if128.miso = if128.mosi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural slave: returns slv_word MSB first, captures mosi on the sample edge for its mode
  logic [1:0] cur_mode;
  logic [7:0] slv_word;
  logic [7:0] s_tx, s_rx;
  int         s_edges;
  logic       s_cpol, s_cpha, s_scs_prev, s_sclk_prev, s_lead;

  always @(negedge clk) begin
    if (!rst) begin
      s_scs_prev  = 1'b1;
      s_sclk_prev = 1'b0;
      if8.miso    = 1'b0;
    end else begin
      if (!if8.scs && s_scs_prev) begin
        s_cpol  = cur_mode[1];
        s_cpha  = cur_mode[0];
        s_tx    = slv_word;
        s_rx    = 8'h00;
        s_edges = 0;
        if (!s_cpha) begin
          if8.miso = s_tx[7];
          s_tx     = {s_tx[6:0], 1'b0};
        end
      end else if (!if8.scs && (if8.sclk != s_sclk_prev)) begin
        s_edges++;
        s_lead = (if8.sclk != s_cpol);
        if (s_lead ^ s_cpha) begin
          s_rx = {s_rx[6:0], if8.mosi};
        end else begin
          if8.miso = s_tx[7];
          s_tx     = {s_tx[6:0], 1'b0};
        end
      end
      s_scs_prev  = if8.scs;
      s_sclk_prev = if8.sclk;
    end
  end

  // One 8-bit frame; done expected 1+(2*2+16)*2 = 41 cycles after acceptance
  task automatic run8(input logic [7:0] tx, input logic [7:0] slv, input logic [1:0] md, input bit poke);
    int         done_at = 0;
    int         ndone = 0;
    int         busy_bad = 0;
    int         rx_early = 0;
    logic [7:0] prev_rx;
    @(negedge clk);
    if8.tx_data = tx;
    if8.mode    = md;
    cur_mode    = md;
    slv_word    = slv;
    if8.start   = 1'b1;
    prev_rx     = if8.rx_data;
    @(posedge clk);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if8.start = 1'b0;
        chk("scs_low_after_start", 128'(if8.scs), 128'(0));
        chk("sclk_setup_cpol", 128'(if8.sclk), 128'(md[1]));
      end
      if (poke && k == 20) begin
        if8.start   = 1'b1;
        if8.tx_data = 8'hFF;
        if8.mode    = ~md;
      end
      if (poke && k == 21) if8.start = 1'b0;
      if (if8.done) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      if (if8.busy != (k <= 41)) busy_bad++;
      if (k < 41 && if8.rx_data != prev_rx) rx_early++;
    end
    chk("done_cycle", 128'(done_at), 128'(41));
    chk("done_count", 128'(ndone), 128'(1));
    chk("busy_span", 128'(busy_bad), 128'(0));
    chk("rx_stable_mid_frame", 128'(rx_early), 128'(0));
    chk("rx_data", 128'(if8.rx_data), 128'(slv));
    chk("mosi_word", 128'(s_rx), 128'(tx));
    chk("sclk_edges", 128'(s_edges), 128'(16));
    chk("sclk_idle", 128'(if8.sclk), 128'(md[1]));
    chk("scs_idle", 128'(if8.scs), 128'(1));
    $display("frame8 mode=%b tx=%h slv=%h rx=%h done_at=%0d", md, tx, slv, if8.rx_data, done_at);
  endtask

  // start held high: frames every 42 cycles, scs high between them
  task automatic run_cont(input logic [7:0] tx, input logic [7:0] slv);
    int ndone = 0;
    int last = 0;
    int sp_bad = 0;
    int rx_bad = 0;
    int mosi_bad = 0;
    int gap = 0;
    int min_gap = 1000;
    @(negedge clk);
    if8.tx_data = tx;
    if8.mode    = 2'b00;
    cur_mode    = 2'b00;
    slv_word    = slv;
    if8.start   = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (if8.scs) begin
        gap++;
      end else begin
        if (ndone > 0 && gap > 0 && gap < min_gap) min_gap = gap;
        gap = 0;
      end
      if (if8.done) begin
        ndone++;
        if (if8.rx_data !== slv) rx_bad++;
        if (s_rx !== tx) mosi_bad++;
        if (last != 0 && (k - last) != 42) sp_bad++;
        last = k;
      end
    end
    if8.start = 1'b0;
    repeat (45) @(negedge clk);
    chk("cont_done_count", 128'(ndone), 128'(3));
    chk("cont_spacing", 128'(sp_bad), 128'(0));
    chk("cont_rx", 128'(rx_bad), 128'(0));
    chk("cont_mosi", 128'(mosi_bad), 128'(0));
    chk("cont_cs_gap", 128'(min_gap >= 1 && min_gap < 1000), 128'(1));
    $display("cont8 tx=%h slv=%h frames=%0d min_gap=%0d", tx, slv, ndone, min_gap);
  endtask

  // 128-bit loopback; done expected 1+(2*1+256)*1 = 259 cycles after acceptance
  task automatic run128(input logic [127:0] tx, input logic [1:0] md);
    int done_at = 0;
    @(negedge clk);
    if128.tx_data = tx;
    if128.mode    = md;
    if128.start   = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 300 && done_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) if128.start = 1'b0;
      if (if128.done) done_at = k;
    end
    chk("lat128", 128'(done_at), 128'(259));
    chk("rx128_loopback", if128.rx_data, tx);
    chk("sclk128_idle", 128'(if128.sclk), 128'(md[1]));
    $display("frame128 mode=%b tx=%h rx=%h done_at=%0d", md, tx, if128.rx_data, done_at);
  endtask

  initial begin
    rst           = 1'b0;
    if8.start     = 1'b0;
    if8.mode      = 2'b00;
    if8.tx_data   = 8'h00;
    if128.start   = 1'b0;
    if128.mode    = 2'b00;
    if128.tx_data = '0;
    cur_mode      = 2'b00;
    slv_word      = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scs", 128'(if8.scs), 128'(1));
    chk("rst_sclk", 128'(if8.sclk), 128'(0));
    chk("rst_mosi", 128'(if8.mosi), 128'(0));
    chk("rst_busy", 128'(if8.busy), 128'(0));
    chk("rst_done", 128'(if8.done), 128'(0));
    chk("rst_rx", 128'(if8.rx_data), 128'(0));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run8(8'hA5, 8'h3C, 2'b00, 1'b0);
    run8(8'hA5, 8'h3C, 2'b01, 1'b0);
    run8(8'hA5, 8'h3C, 2'b10, 1'b0);
    run8(8'hA5, 8'h3C, 2'b11, 1'b0);
    run8(8'hA5, 8'h3C, 2'b00, 1'b1);

    // abort mid-frame with CPOL=1, then a clean frame
    @(negedge clk);
    if8.tx_data = 8'h5A;
    if8.mode    = 2'b11;
    cur_mode    = 2'b11;
    slv_word    = 8'hC3;
    if8.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.start = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_scs", 128'(if8.scs), 128'(1));
    chk("abort_sclk", 128'(if8.sclk), 128'(0));
    chk("abort_busy", 128'(if8.busy), 128'(0));
    begin
      int dn = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (if8.done) dn++;
      end
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (if8.done) dn++;
      end
      chk("abort_no_done", 128'(dn), 128'(0));
    end
    $display("abort8 reset applied mid-frame");
    run8(8'hA5, 8'h3C, 2'b00, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run8(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    end

    run_cont(8'h96, 8'h69);

    run128(128'h00112233_44556677_8899AABB_CCDDEEFF, 2'b00);
    for (int i = 0; i < 2; i++) begin
      run128({$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
